// File: rtl/msg_scroller_pkg.sv
// msg_scroller_pkg: shared types and constants for the message scroller.
// Holds the controller state enum, the 5-bit character code type, the
// blank segment pattern and the named character codes.
package msg_scroller_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOAD,
        ST_SHOW,
        ST_PAUSED
    } state_t;

    typedef logic [4:0] char_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam char_t      CH_BLANK  = 5'd16;
    localparam char_t      CH_DASH   = 5'd17;
    localparam int         NUM_POS   = 10;

endpackage

// File: rtl/msg_scroller_if.sv
// msg_scroller_if: character write port of the message scroller.
// The master presents a character with valid/last; the slave answers with
// ready, and a character moves on any edge where valid and ready are high.
interface msg_scroller_if;
    import msg_scroller_pkg::*;

    logic  wr_valid;
    logic  wr_ready;
    char_t wr_char;
    logic  wr_last;

    modport master (
        output wr_valid,
        output wr_char,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_char,
        input  wr_last,
        output wr_ready
    );

endinterface

// File: rtl/msg_scroller_char_to_seg.sv
// char_to_seg: combinational decoder from a 5-bit character code to an
// active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}.
// Codes 0-15 are hex digits, 17 is a dash, everything else is blank.
module char_to_seg
    import msg_scroller_pkg::*;
(
    input  char_t      code,
    output logic [6:0] seg
);

    // Glyph lookup; unlisted codes fall through to blank
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'd0:    seg = 7'b1000000;
            5'd1:    seg = 7'b1111001;
            5'd2:    seg = 7'b0100100;
            5'd3:    seg = 7'b0110000;
            5'd4:    seg = 7'b0011001;
            5'd5:    seg = 7'b0010010;
            5'd6:    seg = 7'b0000010;
            5'd7:    seg = 7'b1111000;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0010000;
            5'd10:   seg = 7'b0001000;
            5'd11:   seg = 7'b0000011;
            5'd12:   seg = 7'b1000110;
            5'd13:   seg = 7'b0100001;
            5'd14:   seg = 7'b0000110;
            5'd15:   seg = 7'b0001110;
            CH_DASH: seg = 7'b0111111;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/msg_scroller.sv
// msg_scroller: stores a message of character codes written over a
// valid/ready port and scrolls it across ten registered active-low
// seven-segment positions, one step every TICK_DIV clocks, wrapping around.
// Messages of ten characters or fewer are shown statically, left aligned.
// Optional feature: define MSG_SCROLLER_GAP_EN to insert one blank position
// between the last and first character when a long message wraps.
module msg_scroller
    import msg_scroller_pkg::*;
#(
    parameter int MSG_DEPTH = 16,
    parameter int TICK_DIV  = 12_500_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          pause,
    output logic          busy,
    msg_scroller_if.slave wr,
    output logic [6:0]    seg_first_1,
    output logic [6:0]    seg_first_2,
    output logic [6:0]    seg_second_1,
    output logic [6:0]    seg_second_2,
    output logic [6:0]    seg_third_1,
    output logic [6:0]    seg_third_2,
    output logic [6:0]    seg_fourth_1,
    output logic [6:0]    seg_fourth_2,
    output logic [6:0]    seg_fifth_1,
    output logic [6:0]    seg_fifth_2
);

    // len must also hold len+1 when the wrap gap is enabled
    localparam int ADDR_W = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int LEN_W  = $clog2(MSG_DEPTH + 2);
    localparam int IDX_W  = LEN_W + 1;
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef MSG_SCROLLER_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    state_t           state;
    logic [LEN_W-1:0] wr_ptr;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] p;
    logic [LEN_W-1:0] span;
    logic [CNT_W-1:0] tick;
    logic             wr_ready_q;
    logic             busy_q;
    char_t            msg_buf [MSG_DEPTH];

    logic             accept;
    logic             load_done;
    logic             tick_tc;
    logic             scrolling;
    logic             showing;

    logic [IDX_W-1:0] pos_idx  [NUM_POS];
    char_t            pos_char [NUM_POS];
    logic [6:0]       seg_dec  [NUM_POS];
    logic [6:0]       seg_q    [NUM_POS];

    assign accept    = wr.wr_valid && wr_ready_q;
    assign load_done = wr.wr_last || (wr_ptr == LEN_W'(MSG_DEPTH - 1));
    assign tick_tc   = (tick == CNT_W'(TICK_DIV - 1));
    assign scrolling = (int'(len) > NUM_POS);
    assign span      = len + LEN_W'(GAP);
    assign showing   = (state == ST_SHOW) || (state == ST_PAUSED);

    assign wr.wr_ready = wr_ready_q;
    assign busy        = busy_q;

    // Controller: loading, scroll timing, pause and clear, with registered ready/busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_EMPTY;
            wr_ptr     <= '0;
            len        <= '0;
            p          <= '0;
            tick       <= '0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else if (clear) begin
            state      <= ST_EMPTY;
            wr_ptr     <= '0;
            len        <= '0;
            p          <= '0;
            tick       <= '0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY, ST_LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (load_done) begin
                            len        <= wr_ptr + 1'b1;
                            p          <= '0;
                            tick       <= '0;
                            state      <= ST_SHOW;
                            wr_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_SHOW, ST_PAUSED: begin
                    if (pause) begin
                        state <= ST_PAUSED;
                    end else begin
                        state <= ST_SHOW;
                        if (tick_tc) begin
                            tick <= '0;
                            if (scrolling) begin
                                p <= (p == span - 1'b1) ? '0 : p + 1'b1;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    wr_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Message storage; only written while the port is ready, so a shown message is never touched
    always_ff @(posedge clk) begin
        if (!clear && accept) begin
            msg_buf[wr_ptr[ADDR_W-1:0]] <= wr.wr_char;
        end
    end

    // Pick the character for each display position from the scroll pointer and length
    always_comb begin
        for (int k = 0; k < NUM_POS; k++) begin
            pos_idx[k] = IDX_W'(p) + IDX_W'(k);
            if (pos_idx[k] >= IDX_W'(span)) begin
                pos_idx[k] = pos_idx[k] - IDX_W'(span);
            end
            pos_char[k] = CH_BLANK;
            if (showing) begin
                if (scrolling) begin
                    if (pos_idx[k] < IDX_W'(len)) begin
                        pos_char[k] = msg_buf[pos_idx[k][ADDR_W-1:0]];
                    end
                end else if (k < int'(len)) begin
                    pos_char[k] = msg_buf[ADDR_W'(k)];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_POS; g++) begin : g_dec
        char_to_seg u_dec (
            .code (pos_char[g]),
            .seg  (seg_dec[g])
        );
    end

    // All ten positions are captured on the same edge so the display never tears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_POS; k++) begin
                seg_q[k] <= SEG_BLANK;
            end
        end else begin
            for (int k = 0; k < NUM_POS; k++) begin
                seg_q[k] <= seg_dec[k];
            end
        end
    end

    assign seg_first_1  = seg_q[0];
    assign seg_first_2  = seg_q[1];
    assign seg_second_1 = seg_q[2];
    assign seg_second_2 = seg_q[3];
    assign seg_third_1  = seg_q[4];
    assign seg_third_2  = seg_q[5];
    assign seg_fourth_1 = seg_q[6];
    assign seg_fourth_2 = seg_q[7];
    assign seg_fifth_1  = seg_q[8];
    assign seg_fifth_2  = seg_q[9];

endmodule

// File: tb/tb_msg_scroller.sv
// tb_msg_scroller: drives msg_scroller with directed and random traffic and
// compares every cycle against a message-level model (the stored message,
// whether it is being shown, and how many unpaused cycles have elapsed).
// Follows MSG_SCROLLER_GAP_EN the same way the design does.
module tb_msg_scroller;

    localparam int TICK_DIV  = 4;
    localparam int MSG_DEPTH = 16;

`ifdef MSG_SCROLLER_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    localparam logic [69:0] ALL_BLANK = {10{7'h7F}};
    localparam logic [6:0]  GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk;
    logic reset;
    logic clear;
    logic pause;
    logic busy;
    logic [6:0] seg_first_1, seg_first_2, seg_second_1, seg_second_2;
    logic [6:0] seg_third_1, seg_third_2, seg_fourth_1, seg_fourth_2;
    logic [6:0] seg_fifth_1, seg_fifth_2;

    msg_scroller_if wr_bus ();

    msg_scroller #(
        .MSG_DEPTH (MSG_DEPTH),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .pause        (pause),
        .busy         (busy),
        .wr           (wr_bus),
        .seg_first_1  (seg_first_1),
        .seg_first_2  (seg_first_2),
        .seg_second_1 (seg_second_1),
        .seg_second_2 (seg_second_2),
        .seg_third_1  (seg_third_1),
        .seg_third_2  (seg_third_2),
        .seg_fourth_1 (seg_fourth_1),
        .seg_fourth_2 (seg_fourth_2),
        .seg_fifth_1  (seg_fifth_1),
        .seg_fifth_2  (seg_fifth_2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Model state: the message itself, whether it is on display, unpaused cycles since shown
    logic [4:0] m_msg [$];
    bit         m_show;
    int         m_cnt;
    logic [6:0] exp_seg [10];
    logic       exp_ready;
    logic       exp_busy;

    function automatic logic [6:0] glyph(input int code);
        if (code < 16) return GLYPH[code];
        if (code == 17) return 7'b0111111;
        return 7'h7F;
    endfunction

    function automatic logic [6:0] model_pos(input int k);
        int n, lm, idx;
        if (!m_show) return 7'h7F;
        n = m_msg.size();
        if (n <= 10) return (k < n) ? glyph(int'(m_msg[k])) : 7'h7F;
        lm  = n + GAP;
        idx = ((m_cnt / TICK_DIV) + k) % lm;
        if (idx >= n) return 7'h7F;
        return glyph(int'(m_msg[idx]));
    endfunction

    // Reference model: outputs are the rendering of the model state before each edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_msg.delete();
            m_show = 1'b0;
            m_cnt  = 0;
            for (int k = 0; k < 10; k++) exp_seg[k] = 7'h7F;
            exp_ready = 1'b1;
            exp_busy  = 1'b0;
        end else begin
            for (int k = 0; k < 10; k++) exp_seg[k] = model_pos(k);
            if (clear) begin
                m_msg.delete();
                m_show = 1'b0;
                m_cnt  = 0;
            end else if (!m_show) begin
                if (wr_bus.wr_valid) begin
                    m_msg.push_back(wr_bus.wr_char);
                    if (wr_bus.wr_last || m_msg.size() == MSG_DEPTH) begin
                        m_show = 1'b1;
                        m_cnt  = 0;
                    end
                end
            end else if (!pause) begin
                m_cnt++;
            end
            exp_ready = !m_show;
            exp_busy  = m_show;
        end
    end

    function automatic logic [69:0] dut_segs();
        return {seg_first_1, seg_first_2, seg_second_1, seg_second_2, seg_third_1,
                seg_third_2, seg_fourth_1, seg_fourth_2, seg_fifth_1, seg_fifth_2};
    endfunction

    function automatic logic [69:0] model_segs();
        return {exp_seg[0], exp_seg[1], exp_seg[2], exp_seg[3], exp_seg[4],
                exp_seg[5], exp_seg[6], exp_seg[7], exp_seg[8], exp_seg[9]};
    endfunction

    task automatic check_output(input string name, input logic [69:0] actual,
                                input logic [69:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (checking && !reset) begin
            check_output("model_segs", dut_segs(), model_segs());
            check_output("model_wr_ready", 70'(wr_bus.wr_ready), 70'(exp_ready));
            check_output("model_busy", 70'(busy), 70'(exp_busy));
        end
    end

    task automatic apply_stimulus(input logic v, input logic [4:0] ch, input logic last,
                                  input logic pz, input logic clr);
        wr_bus.wr_valid = v;
        wr_bus.wr_char  = ch;
        wr_bus.wr_last  = last;
        pause           = pz;
        clear           = clr;
        @(negedge clk);
    endtask

    task automatic write_char(input logic [4:0] ch, input logic last);
        apply_stimulus(1'b1, ch, last, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        clear           = 1'b0;
        pause           = 1'b0;
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_char  = 5'd0;
        wr_bus.wr_last  = 1'b0;
        #12;
        check_output("reset_segs", dut_segs(), ALL_BLANK);
        check_output("reset_ready", 70'(wr_bus.wr_ready), 70'(1'b1));
        check_output("reset_busy", 70'(busy), 70'(1'b0));
        @(negedge clk);
        reset    = 1'b0;
        checking = 1'b1;

        // Short message 1,2,3
        $display("[TB] short message");
        write_char(5'd1, 1'b0);
        write_char(5'd2, 1'b0);
        write_char(5'd3, 1'b1);
        check_output("short_ready_low", 70'(wr_bus.wr_ready), 70'(1'b0));
        idle(1);
        check_output("short_pos0", 70'(seg_first_1), 70'(7'b1111001));
        check_output("short_pos1", 70'(seg_first_2), 70'(7'b0100100));
        check_output("short_pos2", 70'(seg_second_1), 70'(7'b0110000));
        check_output("short_pos3", 70'(seg_second_2), 70'(7'h7F));
        idle(20 * TICK_DIV);
        check_output("short_static_pos0", 70'(seg_first_1), 70'(7'b1111001));
        check_output("short_static_pos9", 70'(seg_fifth_2), 70'(7'h7F));

        // Clear returns to an empty, blank display
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        check_output("clear_ready", 70'(wr_bus.wr_ready), 70'(1'b1));
        idle(1);
        check_output("clear_blank", dut_segs(), ALL_BLANK);

        // Scroll wrap with codes 0..11
        $display("[TB] scroll wrap");
        for (int i = 0; i < 12; i++) write_char(5'(i), i == 11);
        idle(4);
        check_output("wrap_hold_code0", 70'(seg_first_1), 70'(7'b1000000));
        idle(1);
        check_output("wrap_code1", 70'(seg_first_1), 70'(7'b1111001));
        idle(40);
        check_output("wrap_code11", 70'(seg_first_1), 70'(7'b0000011));
        idle(4);
`ifdef MSG_SCROLLER_GAP_EN
        check_output("wrap_gap_blank", 70'(seg_first_1), 70'(7'h7F));
        idle(4);
        check_output("wrap_gap_code0", 70'(seg_first_1), 70'(7'b1000000));
`else
        check_output("wrap_code0", 70'(seg_first_1), 70'(7'b1000000));
`endif
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Pause at tick count 2, then pause coincident with terminal count
        $display("[TB] pause");
        for (int i = 0; i < 12; i++) write_char(5'(i), i == 11);
        idle(2);
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check_output("pause_held_busy", 70'(busy), 70'(1'b1));
        idle(2);
        check_output("pause_before_adv", 70'(seg_first_1), 70'(7'b1000000));
        idle(1);
        check_output("pause_after_adv", 70'(seg_first_1), 70'(7'b1111001));
        idle(2);
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check_output("pause_tc_no_adv", 70'(seg_first_1), 70'(7'b1111001));
        idle(1);
        check_output("pause_tc_late_adv", 70'(seg_first_1), 70'(7'b0100100));

        // Asynchronous reset in the middle of scrolling
        idle(7);
        #2 reset = 1'b1;
        #1;
        check_output("midreset_segs", dut_segs(), ALL_BLANK);
        check_output("midreset_ready", 70'(wr_bus.wr_ready), 70'(1'b1));
        check_output("midreset_busy", 70'(busy), 70'(1'b0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Full buffer: sixteen characters without last
        $display("[TB] full buffer");
        for (int i = 0; i < 16; i++) write_char(5'(15 - i), 1'b0);
        check_output("full_busy", 70'(busy), 70'(1'b1));
        check_output("full_ready", 70'(wr_bus.wr_ready), 70'(1'b0));
        write_char(5'd17, 1'b1);
        check_output("full_pos0", 70'(seg_first_1), 70'(7'b0001110));
        check_output("full_ready_17th", 70'(wr_bus.wr_ready), 70'(1'b0));
        idle(10);

        // Clear together with the third write of a load
        $display("[TB] clear during load");
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        write_char(5'd7, 1'b0);
        write_char(5'd8, 1'b0);
        apply_stimulus(1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        check_output("clrload_ready", 70'(wr_bus.wr_ready), 70'(1'b1));
        check_output("clrload_busy", 70'(busy), 70'(1'b0));
        idle(1);
        check_output("clrload_blank", dut_segs(), ALL_BLANK);
        write_char(5'd5, 1'b0);
        write_char(5'd17, 1'b1);
        idle(1);
        check_output("clrload_pos0", 70'(seg_first_1), 70'(7'b0010010));
        check_output("clrload_pos1", 70'(seg_first_2), 70'(7'b0111111));
        check_output("clrload_pos2", 70'(seg_second_1), 70'(7'h7F));

        // Random messages, random pauses and stray writes, checked by the model
        $display("[TB] random traffic");
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int m = 0; m < 8; m++) begin
            int mlen;
            mlen = $urandom_range(1, 20);
            for (int i = 0; i < mlen; i++) begin
                if ($urandom_range(0, 3) == 0) apply_stimulus(1'b0, 5'd0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                apply_stimulus(1'b1, 5'($urandom_range(0, 31)), i == mlen - 1, 1'b0,
                               ($urandom_range(0, 40) == 0));
            end
            for (int c = 0; c < 150; c++) begin
                apply_stimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                               1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 1'b0);
            end
            apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        end
        idle(2);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
